hazard_unit_mc: RTL
===================

# hazard_unit_mc

Parametrised hazard and forwarding controller for the five-stage MIPS pipeline. It generates register-file bypass selects for D and E, plus load-use and branch-compare stalls. It also handles two behaviours the single-cycle datapath did not need: a multi-cycle multiply/divide unit, tracked by a countdown, and a data memory that may take several cycles to answer. It drives stall enables for F/D/E/M and bubble (flush) controls for E/W.

## Interface
Parameters:
- REG_AW, 5, register-address width (2^REG_AW architectural registers; register 0 hard-wired zero)
- MD_LAT, 32, multiply/divide latency in cycles, legal range 2..255
- CNT_W, 32, width of each performance counter (used only with HAZARD_PERF_EN)

Ports:
- clk  in  1  pipeline clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high; clears countdown and counters
- rsD, rtD, rsE, rtE  in  REG_AW  source registers in D and E
- writeregE, writeregM, writeregW  in  REG_AW  destination registers
- regwriteE, regwriteM, regwriteW  in  1  destination write enables
- memtoregE, memtoregM  in  1  instruction in that stage is a load
- branchD  in  1  branch compared in D
- mdopD  in  1  D holds mult/div/mfhi/mflo/mthi/mtlo
- mdstartE  in  1  E holds mult/div (starts the unit)
- dmem_reqM, dmem_readyM  in  1  M-stage memory request / completion
- forwardaD, forwardbD  out  1  bypass ALU-out of M into branch comparator
- forwardaE, forwardbE  out  2  E operand select: 00 register file, 01 result of W, 10 ALU-out of M
- stallF, stallD, stallE, stallM  out  1  hold that stage's pipeline register
- flushE, flushW  out  1  insert bubble into E / W register
- md_busy  out  1  multiply/divide result not yet available
- lw_stall_cnt, br_stall_cnt, md_stall_cnt, mem_stall_cnt  out  CNT_W  stall-cycle counters

## Operation
Forwarding (combinational):
- forwardaD = rsD≠0 & rsD==writeregM & regwriteM; forwardbD is the same with rtD.
- forwardaE = 10 if rsE≠0 & rsE==writeregM & regwriteM; else 01 if rsE≠0 & rsE==writeregW & regwriteW; else 00.
- forwardbE is the same with rtE. M has priority over W.

Stall causes (combinational):
- lwstall = memtoregE & (rtE==rsD | rtE==rtD).
- brstall = branchD & (regwriteE & writeregE∈{rsD,rtD} | memtoregM & writeregM∈{rsD,rtD}).
- mdstall = mdopD & md_busy.
- memwait = dmem_reqM & ~dmem_readyM.

Priority and resulting controls:
- memwait = 1: stallF = stallD = stallE = stallM = 1, flushW = 1, flushE = 0. The frozen E must not be flushed.
- else any of lwstall/brstall/mdstall: stallF = stallD = flushE = 1; stallE, stallM, flushW = 0.
- else all stall and flush outputs are 0.

Multiply/divide tracker (two-state FSM plus countdown cnt, width clog2(MD_LAT)):
- IDLE: cnt = 0, md_busy = 0.
- IDLE→BUSY when mdstartE & ~memwait; cnt loads MD_LAT-1.
- BUSY: md_busy = 1. cnt decrements every cycle, including during memwait (the unit runs free).
- BUSY→IDLE when cnt==1 decrements to 0.
- mdstartE while BUSY cannot occur, because mdstall holds the instruction in D. If it is asserted anyway, it is ignored.

## Timing
- Forward, stall and flush outputs are combinational from the current inputs and state, with no added latency.
- A mult in E at cycle t gives md_busy = 1 for cycles t+1 … t+MD_LAT-1. An mfhi in D proceeds at t+MD_LAT.
- Reset value: state IDLE, cnt 0, md_busy 0, all counters 0. With all inputs at 0 after reset, every output is 0.
- Reset asserted mid-countdown aborts the operation; md_busy drops asynchronously.

## Configuration
- HAZARD_PERF_EN defined: each counter increments by 1 in every cycle its cause is the winning stall reason. Priority is mem > md > lw > br, so only one counter increments per cycle. Counters saturate at 2^CNT_W-1 and are cleared only by reset.
- HAZARD_PERF_EN undefined: the counter ports remain and are tied to 0; no counter flops are built.

## Structure
- Package hazard_pkg:
  - forward-select constants FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10
  - md state enum {MD_IDLE, MD_BUSY}
  - stall-cause enum used by the counters
- One sub-module, md_tracker: the FSM and countdown. Inputs are start, reset and clk; output is busy.

## Test plan
- addi $1 in M, add $2,$1,$1 in E (regwriteM = 1, writeregM = 1, rsE = rtE = 1) -> forwardaE = forwardbE = 10. With writeregW = 1 also writing -> still 10.
- lw $3 in E (memtoregE = 1, rtE = 3), add uses $3 in D -> exactly one cycle of stallF = stallD = flushE = 1, lw_stall_cnt = 1.
- MD_LAT = 4: mdstartE at cycle 10, mdopD held -> md_busy in cycles 11–13, stallD in cycles 11–13, proceeds at cycle 14, md_stall_cnt = 3.
- dmem_reqM = 1, dmem_readyM = 0 for 3 cycles while lwstall is also true -> all four stalls = 1, flushW = 1, flushE = 0 for 3 cycles, mem_stall_cnt = 3, lw_stall_cnt unchanged.
- reset pulsed while cnt = 2 -> md_busy = 0 immediately; a following mdopD is not stalled.
- branchD with writeregE = rsD, regwriteE = 1, rsD = 0 -> stall is still asserted. Register 0 is not excluded from the branch compare; this is intentional and the bench must confirm it.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants and types for the multi-cycle MIPS hazard unit.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic {
    MD_IDLE,
    MD_BUSY
  } md_state_e;

  typedef enum logic [2:0] {
    CAUSE_NONE,
    CAUSE_MEM,
    CAUSE_MD,
    CAUSE_LW,
    CAUSE_BR
  } stall_cause_e;

endpackage

// File: rtl/md_tracker.sv
// Multiply/divide busy tracker: two-state FSM with a latency countdown.
module md_tracker
  import hazard_pkg::*;
#(
  parameter int MD_LAT = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy
);

  localparam int CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

  md_state_e       r_state;
  md_state_e       w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Countdown runs free once started; a start while busy is ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      MD_IDLE: begin
        if (start) begin
          w_state_nxt = MD_BUSY;
          w_cnt_nxt   = CW'(MD_LAT - 1);
        end
      end
      MD_BUSY: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1))
          w_state_nxt = MD_IDLE;
      end
    endcase
  end

  assign busy = (r_state == MD_BUSY);

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard/forwarding control for a 5-stage MIPS pipe with multi-cycle md/dmem.
// Optional stall-cycle counters are built only when HAZARD_PERF_EN is defined.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              regwriteE,
  input  logic              regwriteM,
  input  logic              regwriteW,
  input  logic              memtoregE,
  input  logic              memtoregM,
  input  logic              branchD,
  input  logic              mdopD,
  input  logic              mdstartE,
  input  logic              dmem_reqM,
  input  logic              dmem_readyM,
  output logic              forwardaD,
  output logic              forwardbD,
  output logic [1:0]        forwardaE,
  output logic [1:0]        forwardbE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              flushE,
  output logic              flushW,
  output logic              md_busy,
  output logic [CNT_W-1:0]  lw_stall_cnt,
  output logic [CNT_W-1:0]  br_stall_cnt,
  output logic [CNT_W-1:0]  md_stall_cnt,
  output logic [CNT_W-1:0]  mem_stall_cnt
);

  logic w_lwstall;
  logic w_brstall;
  logic w_mdstall;
  logic w_memwait;
  logic w_md_start;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] rm,
    input logic [REG_AW-1:0] rw,
    input logic              wm,
    input logic              ww
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (src != '0) begin
      if (wm && (src == rm))
        sel = FWD_M;
      else if (ww && (src == rw))
        sel = FWD_W;
    end
    return sel;
  endfunction

  assign forwardaD = (rsD != '0) && (rsD == writeregM) && regwriteM;
  assign forwardbD = (rtD != '0) && (rtD == writeregM) && regwriteM;

  assign forwardaE = fwd_sel(rsE, writeregM, writeregW,
                             regwriteM, regwriteW);
  assign forwardbE = fwd_sel(rtE, writeregM, writeregW,
                             regwriteM, regwriteW);

  // Register 0 is deliberately not excluded from the branch compare.
  assign w_lwstall = memtoregE && ((rtE == rsD) || (rtE == rtD));
  assign w_brstall = branchD &&
    ((regwriteE && ((writeregE == rsD) || (writeregE == rtD))) ||
     (memtoregM && ((writeregM == rsD) || (writeregM == rtD))));
  assign w_mdstall = mdopD && md_busy;
  assign w_memwait = dmem_reqM && !dmem_readyM;

  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushE = 1'b0;
    flushW = 1'b0;
    if (w_memwait) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      flushW = 1'b1;
    end else if (w_lwstall || w_brstall || w_mdstall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

  assign w_md_start = mdstartE && !w_memwait;

  md_tracker #(
    .MD_LAT (MD_LAT)
  ) u_md_tracker (
    .clk   (clk),
    .reset (reset),
    .start (w_md_start),
    .busy  (md_busy)
  );

`ifdef HAZARD_PERF_EN
  stall_cause_e     w_cause;
  logic [CNT_W-1:0] r_lw_cnt;
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_md_cnt;
  logic [CNT_W-1:0] r_mem_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    w_cause = CAUSE_NONE;
    if (w_memwait)
      w_cause = CAUSE_MEM;
    else if (w_mdstall)
      w_cause = CAUSE_MD;
    else if (w_lwstall)
      w_cause = CAUSE_LW;
    else if (w_brstall)
      w_cause = CAUSE_BR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lw_cnt  <= '0;
      r_br_cnt  <= '0;
      r_md_cnt  <= '0;
      r_mem_cnt <= '0;
    end else begin
      case (w_cause)
        CAUSE_MEM: r_mem_cnt <= sat_inc(r_mem_cnt);
        CAUSE_MD:  r_md_cnt  <= sat_inc(r_md_cnt);
        CAUSE_LW:  r_lw_cnt  <= sat_inc(r_lw_cnt);
        CAUSE_BR:  r_br_cnt  <= sat_inc(r_br_cnt);
        default: ;
      endcase
    end
  end

  assign lw_stall_cnt  = r_lw_cnt;
  assign br_stall_cnt  = r_br_cnt;
  assign md_stall_cnt  = r_md_cnt;
  assign mem_stall_cnt = r_mem_cnt;
`else
  assign lw_stall_cnt  = '0;
  assign br_stall_cnt  = '0;
  assign md_stall_cnt  = '0;
  assign mem_stall_cnt = '0;
`endif

endmodule
